vga_sync_receiver: RTL and testbench
====================================

# vga_sync_receiver

Receive-side counterpart of the 640x480 VGA timing generator. The block samples the hs, vs, blank and pixel_clk outputs of a timing source and recovers the DrawX/DrawY pixel coordinates. It measures line and frame geometry against expected values, reports lock, and latches sticky error flags. It sits in the video path as a capture front-end for timing-driven logic, and as an in-system checker for the timing generator.

## Interface
- H_TOTAL, 800: pixels per line
- V_TOTAL, 525: lines per frame
- H_ACTIVE, 640: active pixels per displayed line
- V_ACTIVE, 480: displayed lines per frame
- H_SYNC, 96: hs low width, pixels
- V_SYNC, 2: vs low width, counted in hs falling edges
- LOCK_FRAMES, 2: consecutive clean frames required for lock
- Clk  in  1  50 MHz system clock
- Reset  in  1  asynchronous, active-high
- pixel_clk  in  1  25 MHz pixel clock, sampled as data in the Clk domain
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- blank  in  1  active low; 1 = displayable pixel
- err_clr  in  1  clears err_h and err_v
- RxX  out  10  recovered x of the current active pixel
- RxY  out  10  recovered y of the current active line
- rx_active  out  1  RxX/RxY valid (locked and displayable pixel)
- locked  out  1  timing verified
- err_h  out  1  sticky line-timing error
- err_v  out  1  sticky frame-timing error
- meas_htotal  out  10  last measured line length
- meas_vtotal  out  10  last measured frame length

## Operation
- pix_en is asserted in the Clk cycle where pixel_clk = 1 and its previous-cycle sample = 0. hs, vs and blank are sampled only in pix_en cycles.
- Edge strobes are formed from the current and previous pix_en samples: hs_fall, vs_fall, bl_rise, bl_fall.
- Counters, all 10-bit, saturate at 1023:
  - hcnt: pixels since the last hs_fall
  - hsw: pixels with hs low
  - hact: pixels with blank high in the current line
  - vcnt: hs_fall events since the last vs_fall
  - vsw: hs_fall events while vs is low
  - vact: lines with hact > 0
- Line end (hs_fall):
  - Check hcnt == H_TOTAL, hsw == H_SYNC, and hact ∈ {0, H_ACTIVE}.
  - Load meas_htotal, then clear hcnt, hsw and hact.
- Frame end (vs_fall):
  - Check vcnt == V_TOTAL, vsw == V_SYNC, vact == V_ACTIVE.
  - Load meas_vtotal, then clear vcnt, vsw and vact.
- FSM:
  - HUNT: ignore all checks. Go to TRACK on the first vs_fall.
  - TRACK: run checks. Skip line checks until the first hs_fall after entry, because that line is partial. Any check failure sets good_frames = 0 and stays in TRACK. Each clean frame end increments good_frames. Go to LOCKED when good_frames == LOCK_FRAMES.
  - LOCKED: any check failure → TRACK with good_frames = 0.
  - Any state: watchdog. hcnt reaching 1023 with no hs_fall → HUNT.
- Recovered coordinates:
  - RxX is cleared on bl_rise and increments on each pix_en while blank is high.
  - RxY is cleared on vs_fall and increments at each line end where hact > 0.
- Flags:
  - err_h is set by a line check failure; err_v by a frame check failure.
  - Set has priority over a simultaneous err_clr.

## Timing
- Reset state: FSM HUNT. All counters 0. Every output 0: RxX, RxY, rx_active, locked, err_h, err_v, meas_htotal, meas_vtotal.
- pixel_clk rising edge → pix_en: 1 Clk. All outputs are registered one Clk after the pix_en cycle that produced them.
- Total latency from pixel_clk rise to output: 2 Clk.
- locked falls in the cycle after the failing check is evaluated, not at the next frame.
- Simultaneous hs_fall and vs_fall: the line end is processed before the frame end, so vcnt includes that line.
- Reset mid-frame takes effect immediately and asynchronously. Relock requires HUNT, then one partial frame, then LOCK_FRAMES clean frames.

## Structure
- Shared package vga_timing_pkg holds:
  - localparams for the 800/525/640/480/96/2 defaults, shared with the generator
  - enum rx_state_t {HUNT, TRACK, LOCKED}
- Sub-module vga_edge_sampler produces pix_en, the registered hs/vs/blank samples, and the fall/rise strobes.
- The top level holds the counters, checks, FSM and outputs.

## Test plan
- Drive from the vga_controller generator for 4 frames → locked = 1 after the 2nd full frame following the first vs_fall. meas_htotal = 800, meas_vtotal = 525, err_h = err_v = 0.
- Locked, generator at hc = 100, vc = 10 → RxX = 100, RxY = 10, rx_active = 1, 2 Clk after the pixel_clk rise. At hc = 700 → rx_active = 0.
- Inject one 801-pixel line → err_h = 1, locked = 0 in the next cycle, meas_htotal = 801. Relock after 2 clean frames; err_h stays 1 until err_clr.
- Stretch vs to 3 lines → err_v = 1 at vs_fall, FSM in TRACK. Assert err_clr in the same cycle as a new failure → flag remains 1.
- Hold hs high for 1100 pixels → FSM HUNT, locked = 0. Resume normal sync → locked again after the partial frame plus 2 frames.
- Assert Reset mid-line while locked → all outputs 0 immediately. Release → normal relock sequence.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and receiver state encoding.
package vga_timing_pkg;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int H_SYNC      = 96;
  localparam int V_SYNC      = 2;
  localparam int LOCK_FRAMES = 2;

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} rx_state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_sync_receiver_sampler.sv
// Oversamples pixel_clk in the Clk domain and forms per-pixel samples and sync edge strobes.
module vga_edge_sampler (
  input  logic Clk,
  input  logic Reset,
  input  logic pixel_clk,
  input  logic hs,
  input  logic vs,
  input  logic blank,
  output logic pix_en,
  output logic hs_s,
  output logic vs_s,
  output logic bl_s,
  output logic hs_fall,
  output logic vs_fall,
  output logic bl_rise,
  output logic bl_fall
);
  logic pclk_q, pclk_p;
  logic hs_p, vs_p, bl_p;

  // hs/vs/blank are captured on the same edge as pixel_clk, so they are valid in pix_en cycles
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pclk_q <= 1'b0;
      pclk_p <= 1'b0;
      hs_s   <= 1'b0;
      vs_s   <= 1'b0;
      bl_s   <= 1'b0;
      hs_p   <= 1'b0;
      vs_p   <= 1'b0;
      bl_p   <= 1'b0;
    end else begin
      pclk_q <= pixel_clk;
      pclk_p <= pclk_q;
      hs_s   <= hs;
      vs_s   <= vs;
      bl_s   <= blank;
      if (pix_en) begin
        hs_p <= hs_s;
        vs_p <= vs_s;
        bl_p <= bl_s;
      end
    end
  end

  assign pix_en  = pclk_q & ~pclk_p;
  assign hs_fall = pix_en & hs_p & ~hs_s;
  assign vs_fall = pix_en & vs_p & ~vs_s;
  assign bl_rise = pix_en & ~bl_p & bl_s;
  assign bl_fall = pix_en & bl_p & ~bl_s;
endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from sampled VGA syncs, checks geometry, and reports lock.
// state  | meaning
// HUNT   | no timing reference; checks ignored until a vs falling edge
// TRACK  | checks running; counting clean frames towards lock
// LOCKED | timing verified; coordinates valid during active video
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pixel_clk,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  input  logic       err_clr,
  output logic [9:0] RxX,
  output logic [9:0] RxY,
  output logic       rx_active,
  output logic       locked,
  output logic       err_h,
  output logic       err_v,
  output logic [9:0] meas_htotal,
  output logic [9:0] meas_vtotal
);
  localparam logic [9:0] HT = 10'(H_TOTAL);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] HS = 10'(H_SYNC);
  localparam logic [9:0] VS = 10'(V_SYNC);
  localparam logic [2:0] LF = 3'(LOCK_FRAMES);

  logic pix_en, hs_s, vs_s, bl_s, hs_fall, vs_fall, bl_rise, bl_fall;

  vga_edge_sampler u_sampler (
    .Clk(Clk), .Reset(Reset), .pixel_clk(pixel_clk),
    .hs(hs), .vs(vs), .blank(blank),
    .pix_en(pix_en), .hs_s(hs_s), .vs_s(vs_s), .bl_s(bl_s),
    .hs_fall(hs_fall), .vs_fall(vs_fall), .bl_rise(bl_rise), .bl_fall(bl_fall)
  );

  logic [9:0] hcnt, hsw, hact, vcnt, vsw, vact;
  logic [9:0] vcnt_l, vsw_l, vact_l;
  logic       line_ok, frame_ok, line_fail, frame_fail, watchdog, frame_clean, stay_locked;
  rx_state_t  state;
  logic [2:0] good_frames;
  logic       skip_line, line_bad;

  // vertical counts include a line ending on the same pixel as the frame
  always_comb begin
    vcnt_l      = hs_fall ? sat_inc(vcnt) : vcnt;
    vsw_l       = (hs_fall && !vs_s) ? sat_inc(vsw) : vsw;
    vact_l      = (hs_fall && hact != 10'd0) ? sat_inc(vact) : vact;
    line_ok     = (hcnt == HT) && (hsw == HS) && (hact == 10'd0 || hact == HA);
    frame_ok    = (vcnt_l == VT) && (vsw_l == VS) && (vact_l == VA);
    line_fail   = hs_fall && (state != HUNT) && !skip_line && !line_ok;
    frame_fail  = vs_fall && (state != HUNT) && !frame_ok;
    frame_clean = vs_fall && frame_ok && !line_bad && !line_fail;
    watchdog    = pix_en && (hcnt == CNT_MAX) && !hs_fall;
    stay_locked = (state == LOCKED) && !line_fail && !frame_fail && !watchdog;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hcnt        <= '0;
      hsw         <= '0;
      hact        <= '0;
      vcnt        <= '0;
      vsw         <= '0;
      vact        <= '0;
      RxX         <= '0;
      RxY         <= '0;
      meas_htotal <= '0;
      meas_vtotal <= '0;
    end else if (pix_en) begin
      if (hs_fall) begin
        meas_htotal <= hcnt;
        hcnt        <= 10'd1;
        hsw         <= 10'd1;
        hact        <= {9'd0, bl_s};
      end else begin
        hcnt <= sat_inc(hcnt);
        if (!hs_s) hsw <= sat_inc(hsw);
        if (bl_s)  hact <= sat_inc(hact);
      end
      if (vs_fall) begin
        meas_vtotal <= vcnt_l;
        vcnt        <= '0;
        vsw         <= '0;
        vact        <= '0;
      end else begin
        vcnt <= vcnt_l;
        vsw  <= vsw_l;
        vact <= vact_l;
      end
      if (bl_rise)   RxX <= '0;
      else if (bl_s) RxX <= RxX + 10'd1;
      if (vs_fall)                        RxY <= '0;
      else if (hs_fall && hact != 10'd0)  RxY <= RxY + 10'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= HUNT;
      good_frames <= '0;
      skip_line   <= 1'b0;
      line_bad    <= 1'b0;
      locked      <= 1'b0;
      rx_active   <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
    end else begin
      if (line_fail)    err_h <= 1'b1;
      else if (err_clr) err_h <= 1'b0;
      if (frame_fail)   err_v <= 1'b1;
      else if (err_clr) err_v <= 1'b0;

      if (pix_en) begin
        if (hs_fall) skip_line <= 1'b0;
        if (vs_fall)        line_bad <= 1'b0;
        else if (line_fail) line_bad <= 1'b1;
        if (bl_fall || !stay_locked) rx_active <= 1'b0;
        else if (bl_s)               rx_active <= 1'b1;

        if (watchdog) begin
          state       <= HUNT;
          good_frames <= '0;
          locked      <= 1'b0;
        end else begin
          case (state)
            HUNT: if (vs_fall) begin
              state       <= TRACK;
              good_frames <= '0;
              skip_line   <= 1'b1;
            end
            TRACK: begin
              if (line_fail || frame_fail) begin
                good_frames <= '0;
              end else if (frame_clean) begin
                good_frames <= good_frames + 3'd1;
                if (good_frames + 3'd1 == LF) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
            LOCKED: if (line_fail || frame_fail) begin
              state       <= TRACK;
              good_frames <= '0;
              locked      <= 1'b0;
            end
            default: begin
              state  <= HUNT;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench: small-geometry sync source driving the receiver, expected values hand-derived.
module tb_vga_sync_receiver;
  localparam int HT = 20, HA = 12, HSS = 14, HSW = 3;
  localparam int VT = 12, VA = 8, VSS = 9;

  logic       Clk, Reset, pixel_clk, hs, vs, blank, err_clr;
  logic [9:0] RxX, RxY, meas_htotal, meas_vtotal;
  logic       rx_active, locked, err_h, err_v;

  int n_checks = 0;
  int n_err    = 0;
  int hc, vc, long_vc, vs_end;
  bit hs_stuck;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC(HSW), .V_SYNC(2), .LOCK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pixel_clk(pixel_clk), .hs(hs), .vs(vs), .blank(blank),
    .err_clr(err_clr), .RxX(RxX), .RxY(RxY), .rx_active(rx_active), .locked(locked),
    .err_h(err_h), .err_v(err_v), .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  initial begin
    #2ms;
    $display("FAIL sim_timeout: simulation did not finish, errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // one source pixel: pixel_clk high for one Clk, low for one Clk
  task automatic pixel();
    @(negedge Clk);
    hc++;
    if (hc >= ((vc == long_vc) ? HT + 1 : HT)) begin
      if (vc == long_vc) long_vc = -1;
      hc = 0;
      vc = (vc + 1) % VT;
    end
    pixel_clk = 1'b1;
    hs    = hs_stuck || !(hc >= HSS && hc < HSS + HSW);
    vs    = !(vc >= VSS && vc <= vs_end);
    blank = (hc < HA) && (vc < VA);
    @(negedge Clk);
    pixel_clk = 1'b0;
  endtask

  // advance to pixel (h,v) and settle past the output register edge
  task automatic run_to(input int h, input int v, input bit clr_eval);
    int n = 0;
    do begin
      pixel();
      n++;
    end while (!(hc == h && vc == v) && n < 3000);
    if (clr_eval) err_clr = 1'b1;
    @(posedge Clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge Clk);
    err_clr = 1'b1;
    @(negedge Clk);
    err_clr = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b0; pixel_clk = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; err_clr = 1'b0;
    hc = HT - 1; vc = VT - 1; long_vc = -1; vs_end = VSS + 1; hs_stuck = 1'b0;
    #5 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_rxx", RxX, 0);
    check("rst_rxy", RxY, 0);
    check("rst_active", rx_active, 0);
    check("rst_err_h", err_h, 0);
    check("rst_err_v", err_v, 0);
    check("rst_meas_h", meas_htotal, 0);
    check("rst_meas_v", meas_vtotal, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // acquisition: first vs_fall enters TRACK, lock after two clean frames
    run_to(0, 9, 0);
    check("acq_meas_v_partial", meas_vtotal, 9);
    check("acq_locked0", locked, 0);
    run_to(0, 9, 0);
    check("acq_meas_v", meas_vtotal, VT);
    check("acq_locked1", locked, 0);
    run_to(0, 9, 0);
    check("acq_locked2", locked, 1);
    check("acq_meas_h", meas_htotal, HT);
    check("acq_err_h", err_h, 0);
    check("acq_err_v", err_v, 0);

    // coordinate recovery
    run_to(5, 3, 0);
    check("coord_x", RxX, 5);
    check("coord_y", RxY, 3);
    check("coord_active", rx_active, 1);
    run_to(15, 3, 0);
    check("coord_blank_active", rx_active, 0);
    check("coord_x_hold", RxX, HA - 1);
    run_to(0, 4, 0);
    check("coord_x_restart", RxX, 0);
    check("coord_y_next", RxY, 4);
    check("coord_active_restart", rx_active, 1);

    // one long line
    long_vc = 5;
    run_to(14, 6, 0);
    check("long_err_h", err_h, 1);
    check("long_unlock", locked, 0);
    check("long_meas_h", meas_htotal, HT + 1);
    run_to(5, 7, 0);
    check("long_no_active", rx_active, 0);
    run_to(0, 9, 0);
    check("long_dirty_frame", locked, 0);
    run_to(0, 9, 0);
    check("long_clean1", locked, 0);
    run_to(0, 9, 0);
    check("long_relock", locked, 1);
    check("long_err_sticky", err_h, 1);
    clear_errs();
    check("long_err_cleared", err_h, 0);

    // stretched vertical sync, then set-vs-clear priority
    vs_end = VSS + 2;
    run_to(0, 0, 0);
    vs_end = VSS + 1;
    run_to(0, 9, 0);
    check("vs3_err_v", err_v, 1);
    check("vs3_unlock", locked, 0);
    clear_errs();
    check("vs3_err_cleared", err_v, 0);
    vs_end = VSS + 2;
    run_to(0, 0, 0);
    vs_end = VSS + 1;
    run_to(0, 9, 1);
    check("vs3_set_beats_clr", err_v, 1);
    run_to(0, 9, 0);
    check("vs3_clean1", locked, 0);
    run_to(0, 9, 0);
    check("vs3_relock_track", locked, 1);
    check("vs3_err_sticky", err_v, 1);

    // hs stuck high: watchdog drops to HUNT, which ignores the next checks
    hs_stuck = 1'b1;
    repeat (1100) pixel();
    @(posedge Clk);
    #1;
    check("wd_unlock", locked, 0);
    clear_errs();
    hs_stuck = 1'b0;
    run_to(15, 4, 0);
    check("wd_meas_sat", meas_htotal, 1023);
    check("wd_hunt_no_err_h", err_h, 0);
    run_to(0, 9, 0);
    check("wd_hunt_no_err_v", err_v, 0);
    check("wd_locked0", locked, 0);
    run_to(0, 9, 0);
    check("wd_locked1", locked, 0);
    run_to(0, 9, 0);
    check("wd_relock", locked, 1);

    // asynchronous reset mid-line while locked
    run_to(5, 2, 0);
    check("mid_rxx_pre", RxX, 5);
    #3 Reset = 1'b1;
    #1;
    check("mid_rst_outputs",
          {RxX, RxY, rx_active, locked, err_h, err_v, meas_htotal, meas_vtotal}, 0);
    @(negedge Clk);
    Reset = 1'b0;
    run_to(0, 9, 0);
    check("mid_locked0", locked, 0);
    run_to(0, 9, 0);
    check("mid_locked1", locked, 0);
    run_to(0, 9, 0);
    check("mid_relock", locked, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
